// File: rtl/paralelo_serial_if.sv
// Byte-side handshake and serial line of the PHY transmit serializer.
// Upstream drives the byte; the serializer drives ready and the bit stream.
interface paralelo_serial_if;
  logic [7:0] data_in;
  logic       valid_in;
  logic       ready_out;
  logic       data_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out
  );
endinterface

// File: rtl/paralelo_serial.sv
// Byte-to-bit serializer, MSB first, with comma sync preamble
// after reset and comma idle fill when upstream has no byte.
module paralelo_serial #(
  parameter int         SYNC_BC = 4,
  parameter logic [7:0] COMMA   = 8'hBC
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  paralelo_serial_if.slave  bus
);

  typedef enum logic {
    SYNC,
    ACTIVE
  } state_t;

  localparam logic [7:0] SYNC_LAST = 8'(SYNC_BC - 2);

  state_t     state, state_nxt;
  logic [2:0] bit_cnt;
  logic [7:0] cur_byte, byte_nxt;
  logic [7:0] sync_cnt, sync_nxt;
  logic       data_q;
  logic       slot_end;

  assign slot_end      = (bit_cnt == 3'd7);
  assign bus.ready_out = (state == ACTIVE) && slot_end;
  assign bus.data_out  = data_q;

  always_ff @(posedge clk_32f) begin
    if (!reset_L) begin
      state    <= SYNC;
      bit_cnt  <= 3'd0;
      cur_byte <= COMMA;
      sync_cnt <= 8'd0;
      data_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      bit_cnt  <= bit_cnt + 3'd1;
      cur_byte <= byte_nxt;
      sync_cnt <= sync_nxt;
      data_q   <= cur_byte[3'd7 - bit_cnt];
    end
  end

  // Next byte is chosen only at the slot boundary.
  always_comb begin
    state_nxt = state;
    byte_nxt  = cur_byte;
    sync_nxt  = sync_cnt;
    if (slot_end) begin
      unique case (state)
        SYNC: begin
          byte_nxt = COMMA;
          sync_nxt = sync_cnt + 8'd1;
          if (sync_cnt == SYNC_LAST)
            state_nxt = ACTIVE;
        end
        ACTIVE: begin
          byte_nxt = bus.valid_in
                   ? bus.data_in
                   : COMMA;
        end
        default: begin
          state_nxt = SYNC;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_paralelo_serial.sv
// Directed bench for paralelo_serial: sync preamble, data,
// idle fill, back-to-back bytes and mid-byte reset.
module tb_paralelo_serial;

  logic clk_32f = 1'b0;
  logic reset_L = 1'b0;
  int   n_cmp   = 0;
  int   n_bad   = 0;

  paralelo_serial_if bus ();

  paralelo_serial #(
    .SYNC_BC (4),
    .COMMA   (8'hBC)
  ) dut (
    .clk_32f (clk_32f),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  always #5 clk_32f = ~clk_32f;

  task automatic check(
    input string      tag,
    input logic [7:0] got,
    input logic [7:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_32f);
    #1;
  endtask

  // One 8-edge slot: rebuild the byte and the ready pattern.
  // rdy set means ready is expected after the 7th edge only.
  task automatic slot(
    input string      tag,
    input logic [7:0] exp_byte,
    input logic       rdy
  );
    logic [7:0] b;
    logic [7:0] rp;
    b  = 8'h00;
    rp = 8'h00;
    for (int i = 0; i < 8; i++) begin
      tick();
      b  = {b[6:0], bus.data_out};
      rp = {rp[6:0], bus.ready_out};
    end
    check({tag, "_byte"}, b, exp_byte);
    check({tag, "_rdy"}, rp, rdy ? 8'h02 : 8'h00);
  endtask

  task automatic send(input logic v, input logic [7:0] d);
    bus.valid_in = v;
    bus.data_in  = d;
  endtask

  initial begin
    send(1'b0, 8'h00);
    reset_L = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_dout", {7'd0, bus.data_out}, 8'h00);
      check("rst_rdy", {7'd0, bus.ready_out}, 8'h00);
    end

    // Data offered from release onward must wait out the sync.
    reset_L = 1'b1;
    send(1'b1, 8'hA5);
    slot("sync1", 8'hBC, 1'b0);
    slot("sync2", 8'hBC, 1'b0);
    slot("sync3", 8'hBC, 1'b0);
    slot("sync4", 8'hBC, 1'b1);
    slot("a5_1", 8'hA5, 1'b1);
    send(1'b1, 8'h3C);
    slot("a5_2", 8'hA5, 1'b1);
    send(1'b0, 8'h77);
    slot("3c", 8'h3C, 1'b1);
    slot("idle1", 8'hBC, 1'b1);
    slot("idle2", 8'hBC, 1'b1);

    send(1'b1, 8'h01);
    slot("idle3", 8'hBC, 1'b1);
    send(1'b1, 8'hFF);
    slot("b2b_01", 8'h01, 1'b1);
    send(1'b0, 8'h00);
    slot("b2b_ff", 8'hFF, 1'b1);
    slot("idle4", 8'hBC, 1'b1);

    // Abandon 8'h5A after three of its bits.
    send(1'b1, 8'h5A);
    slot("pre5a", 8'hBC, 1'b1);
    tick();
    check("5a_b7", {7'd0, bus.data_out}, 8'h00);
    tick();
    check("5a_b6", {7'd0, bus.data_out}, 8'h01);
    tick();
    check("5a_b5", {7'd0, bus.data_out}, 8'h00);
    reset_L = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("mid_dout", {7'd0, bus.data_out}, 8'h00);
      check("mid_rdy", {7'd0, bus.ready_out}, 8'h00);
    end
    reset_L = 1'b1;
    slot("resync1", 8'hBC, 1'b0);
    slot("resync2", 8'hBC, 1'b0);
    slot("resync3", 8'hBC, 1'b0);
    slot("resync4", 8'hBC, 1'b1);
    send(1'b1, 8'h11);
    slot("5a_new", 8'h5A, 1'b1);

    send(1'b1, 8'h22);
    slot("lb_11", 8'h11, 1'b1);
    send(1'b1, 8'h33);
    slot("lb_22", 8'h22, 1'b1);
    send(1'b0, 8'h00);
    slot("lb_33", 8'h33, 1'b1);
    slot("lb_idle", 8'hBC, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial.md
# paralelo_serial

Byte-to-bit serializer for the transmit side of the PHY link, the counterpart of the serial-to-parallel receiver. It sends a configurable number of 8'hBC comma bytes after reset so that the receiver can synchronize. It then serializes one parallel byte per 8-bit slot, MSB first, on a single `clk_32f` clock. Whenever upstream has no valid byte for a slot, it inserts the comma 8'hBC as idle.

## Interface
- `SYNC_BC`, default 4: number of comma bytes sent after reset before any data is accepted; legal range 2..255.
- `COMMA`, default 8'hBC: idle/synchronization byte.

- `clk_32f` input 1: bit clock, one serial bit per rising edge. It is the only clock; one clock; reset is synchronous and active-low.
- `reset_L` input 1: synchronous, active-low reset.
- `data_in` input 8: parallel byte to transmit.
- `valid_in` input 1: `data_in` holds a byte to send.
- `ready_out` output 1: high during the cycle in which `data_in`/`valid_in` are sampled on the next edge.
- `data_out` output 1: registered serial bit stream.

## Operation
- Internal registers:
  - `bit_cnt` is a 3-bit counter.
  - `cur_byte` is 8 bits.
  - State is SYNC or ACTIVE.
  - `sync_cnt` is an 8-bit counter.
- Reset (`reset_L`=0 at an edge):
  - `bit_cnt`=0, `cur_byte`=COMMA, state=SYNC, `sync_cnt`=0, `data_out`=0.
  - Hence `ready_out`=0.
- Every edge with `reset_L`=1:
  - `data_out` <= `cur_byte[7-bit_cnt]`.
  - `bit_cnt` <= `bit_cnt`+1, wrapping 7->0.
- Byte boundary (edge with `bit_cnt`==7) in SYNC:
  - `cur_byte` <= COMMA and `sync_cnt` <= `sync_cnt`+1; `valid_in` is ignored.
  - If `sync_cnt`==SYNC_BC-2 before the increment, state <= ACTIVE.
  - Result: exactly SYNC_BC commas precede the first data slot, counting the byte loaded at reset.
- Byte boundary in ACTIVE:
  - If `valid_in`=1, `cur_byte` <= `data_in`.
  - If `valid_in`=0, `cur_byte` <= COMMA.
  - State is unchanged.
- `ready_out` = (state==ACTIVE) && (`bit_cnt`==7). It is decoded from registers only, with no combinational path from the inputs.
- Handshake:
  - A byte is consumed only on an edge where `ready_out`=1 and `valid_in`=1.
  - Upstream holds `data_in`/`valid_in` until it sees that condition.
  - Values presented when `ready_out`=0 are ignored.
- A valid byte equal to COMMA is sent unchanged. The receiver treats it as idle, so avoiding it is upstream's responsibility.
- Once ACTIVE, the block never returns to SYNC except through reset.

## Timing
- Edge n is the n-th rising edge after `reset_L` goes high, starting at n=1.
- Byte m is the m-th byte emitted; byte 1 is the COMMA loaded at reset.
- Byte m (m≥2) is loaded at edge 8(m-1).
- After edge n, `data_out` = bit 7-((n-1) mod 8) of byte ⌈n/8⌉.
- With SYNC_BC=4:
  - Bytes 1-4 are COMMA.
  - `ready_out` first goes high after edge 31, and the first data sample occurs at edge 32.
  - The MSB of that byte is on `data_out` after edge 33 and the LSB after edge 40.
  - `ready_out` is then high every 8th cycle: after edges 39, 47, ...
- Latency: 1 edge from the sampling edge to the MSB on `data_out`, 8 edges to the LSB.
- Throughput: one byte per 8 clocks, with no bubbles for back-to-back valid data.
- Reset mid-byte: the partial byte is abandoned at the reset edge and the full SYNC sequence restarts. There is no stale data after reset release.
- Reset asserted in the same edge as a handshake takes priority; the byte is not consumed.

## Test plan
- Reset and sync: hold `reset_L`=0 for 3 edges, then release with `valid_in`=0 -> `data_out`=0 and `ready_out`=0 during reset. After edges 1-32, `data_out` shows 10111100 four times, and `ready_out` is 0 until after edge 31.
- Single byte: `data_in`=8'hA5 with `valid_in`=1 from reset release onward -> data is ignored during SYNC. At edge 32 it is sampled, and `data_out` after edges 33-40 = 1,0,1,0,0,1,0,1. If `valid_in` is held high, the byte repeats.
- Idle insertion: one 8'h3C byte, then `valid_in`=0 -> after 3C, the stream shows 10111100 in every following slot.
- Back-to-back: 8'h01 then 8'hFF, each held until a handshake -> bits 00000001 immediately followed by 11111111; `ready_out` pulses exactly once per 8 clocks.
- Reset mid-operation: assert `reset_L`=0 after edge 36, during the 4th bit of a data byte -> outputs are at reset values; after release, four fresh commas are sent before the next `ready_out`.
- Loopback: connect `data_out` to the serial-to-parallel receiver (`clk_4f` = `clk_32f`/8, phase-aligned) and send 8'h11, 8'h22, 8'h33 -> the receiver's `valid_out` rises and `data_out` shows 11, 22, 33 in order. During idle slots `valid_out` is 0.
